// File: rtl/weight_biu.sv
// weight_biu: read-side bus interface unit for convolution weights.
// Requests the ICB arbiter, issues sequential 32-bit read commands, buffers the
// responses in a show-ahead FIFO and streams them to the weight buffer.
// Because the response path has no back-pressure, a command is only issued when
// FIFO space is reserved for its response (outstanding + fifo_cnt < FIFO_DEPTH).
// Optional feature: define WEIGHT_BIU_PERF_EN to add the perf_stall_cnt output.
module weight_biu #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_num,
  output logic             busy,
  output logic             done,
  output logic             weight_biu2arb_req,
  output logic [31:0]      weight_biu2arb_addr,
  output logic             weight_biu2arb_vld,
  input  logic             weight_biu2arb_rdy,
  input  logic [31:0]      arb2weight_biu_data,
  input  logic             arb2weight_biu_vld,
  output logic             arb2weight_biu_rdy,
  output logic [31:0]      wbuf_data,
  output logic             wbuf_vld,
  input  logic             wbuf_rdy
`ifdef WEIGHT_BIU_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_REQ      = 3'd1;
  localparam logic [2:0] S_WAIT_RSP = 3'd2;
  localparam logic [2:0] S_FLUSH    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       r_state;
  logic [29:0]      r_base;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_rsp_cnt;
  logic [CNT_W-1:0] r_pop_cnt;
  logic             r_granted;
  logic             r_busy;
  logic             r_done;
  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_fifo_cnt;

  logic             w_xfer;
  logic             w_start_ok;
  logic             w_more;
  logic             w_credit_ok;
  logic             w_vld;
  logic             w_acc;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [CNT_W-1:0] w_outstanding;
  logic [CNT_W:0]   w_used;
  logic [31:0]      w_addr;
  logic             w_unused_lsb;

  // Byte offset within a word is irrelevant: commands are always word aligned.
  assign w_unused_lsb = ^base_addr[1:0];

  assign w_xfer        = (r_state == S_REQ) || (r_state == S_WAIT_RSP);
  assign w_start_ok    = (r_state == S_IDLE) && start && !r_busy;
  assign w_more        = r_issue_cnt < r_num;
  assign w_outstanding = r_issue_cnt - r_rsp_cnt;
  // Credits in use: responses still in flight plus words parked in the FIFO.
  assign w_used        = {1'b0, w_outstanding} + {{(CNT_W-PTR_W){1'b0}}, r_fifo_cnt};
  assign w_credit_ok   = w_used < CREDIT_MAX;
  assign w_vld         = (r_state == S_REQ) && r_granted && w_more && w_credit_ok;
  assign w_acc         = w_vld && weight_biu2arb_rdy;
  // Requires CNT_W <= 30; the sum wraps modulo 2^32.
  assign w_addr        = {r_base, 2'b00} + {{(30-CNT_W){1'b0}}, r_issue_cnt, 2'b00};

  assign w_push  = arb2weight_biu_vld && w_xfer;
  assign w_empty = (r_fifo_cnt == '0);
  assign w_pop   = !w_empty && wbuf_rdy;

  assign busy                = r_busy;
  assign done                = r_done;
  assign weight_biu2arb_req  = w_xfer;
  assign weight_biu2arb_vld  = w_vld;
  assign weight_biu2arb_addr = w_addr;
  assign arb2weight_biu_rdy  = w_xfer;
  assign wbuf_vld            = !w_empty;
  assign wbuf_data           = w_empty ? 32'h0 : r_mem[r_rd_ptr];

  // Control FSM, transfer parameters, handshake counters and busy/done flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_num       <= '0;
      r_issue_cnt <= '0;
      r_rsp_cnt   <= '0;
      r_pop_cnt   <= '0;
      r_granted   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_done) begin
        r_busy <= 1'b0;
      end
      if (w_acc) begin
        r_issue_cnt <= r_issue_cnt + CNT_ONE;
      end
      if (w_push) begin
        r_rsp_cnt <= r_rsp_cnt + CNT_ONE;
      end
      if (w_pop) begin
        r_pop_cnt <= r_pop_cnt + CNT_ONE;
      end
      // Grant is only honoured while req is high; early/lagging rdy is ignored.
      if (r_state == S_REQ) begin
        if (weight_biu2arb_rdy) begin
          r_granted <= 1'b1;
        end
      end else begin
        r_granted <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_busy <= 1'b1;
            if (word_num != '0) begin
              r_base      <= base_addr[31:2];
              r_num       <= word_num;
              r_issue_cnt <= '0;
              r_rsp_cnt   <= '0;
              r_pop_cnt   <= '0;
              r_state     <= S_REQ;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (w_acc && ((r_issue_cnt + CNT_ONE) == r_num)) begin
            r_state <= S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          // Hold req until every response is in so the arbiter keeps routing here.
          if (r_rsp_cnt == r_num) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (r_pop_cnt == r_num) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide at any fill level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      assert (!(w_push && !w_pop && (r_fifo_cnt == FIFO_FULL)));
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the read port is masked when empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= arb2weight_biu_data;
    end
  end

`ifdef WEIGHT_BIU_PERF_EN
  logic [31:0] r_perf_cnt;
  logic        w_stall;

  assign w_stall        = w_xfer && (!weight_biu2arb_rdy || (w_more && !w_credit_ok));
  assign perf_stall_cnt = r_perf_cnt;

  // Stall counter: arbiter not ready, or credit exhausted with words left to issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_cnt <= '0;
    end else if (w_start_ok) begin
      r_perf_cnt <= '0;
    end else if (w_stall) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_weight_biu.sv
// tb_weight_biu: directed bench for weight_biu with a small arbiter model
// (configurable grant lag / toggling rdy, in-order responses with random delay).
module tb_weight_biu;

  localparam logic [31:0] KEY = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] word_num = '0;
  logic        busy, done;
  logic        weight_biu2arb_req, weight_biu2arb_vld;
  logic [31:0] weight_biu2arb_addr;
  logic        weight_biu2arb_rdy = 1'b0;
  logic [31:0] arb2weight_biu_data = '0;
  logic        arb2weight_biu_vld = 1'b0;
  logic        arb2weight_biu_rdy;
  logic [31:0] wbuf_data;
  logic        wbuf_vld;
  logic        wbuf_rdy = 1'b0;
`ifdef WEIGHT_BIU_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  weight_biu #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .base_addr           (base_addr),
    .word_num            (word_num),
    .busy                (busy),
    .done                (done),
    .weight_biu2arb_req  (weight_biu2arb_req),
    .weight_biu2arb_addr (weight_biu2arb_addr),
    .weight_biu2arb_vld  (weight_biu2arb_vld),
    .weight_biu2arb_rdy  (weight_biu2arb_rdy),
    .arb2weight_biu_data (arb2weight_biu_data),
    .arb2weight_biu_vld  (arb2weight_biu_vld),
    .arb2weight_biu_rdy  (arb2weight_biu_rdy),
    .wbuf_data           (wbuf_data),
    .wbuf_vld            (wbuf_vld),
    .wbuf_rdy            (wbuf_rdy)
`ifdef WEIGHT_BIU_PERF_EN
    ,
    .perf_stall_cnt      (perf_stall_cnt)
`endif
  );

  int errs = 0;
  int checks = 0;

  // Arbiter model knobs.
  int arb_lag = 2;
  bit arb_toggle = 1'b0;
  bit tog = 1'b0;
  int dmin = 2;
  int dmax = 2;

  // Monitor state.
  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];
  logic [31:0] pend_addr[$];
  int pend_due[$];
  int cyc = 0;
  int last_due = 0;
  int req_run = 0;
  logic prev_req = 1'b0;
  int push_cnt, done_cnt, done_cyc, start_cyc, req_cycles, vld_cycles, wv_cycles;
  int rsp_at_fall, first_grant, first_acc, first_push, first_wv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    addr_q.delete();
    data_q.delete();
    push_cnt = 0;
    done_cnt = 0;
    done_cyc = -1;
    start_cyc = -1;
    req_cycles = 0;
    vld_cycles = 0;
    wv_cycles = 0;
    rsp_at_fall = -1;
    first_grant = -1;
    first_acc = -1;
    first_push = -1;
    first_wv = -1;
  endtask

  // Sample every handshake mid-cycle, where all inputs and outputs are settled.
  always @(negedge clk) begin
    int d;
    cyc++;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
      last_due = 0;
      req_run = 0;
      prev_req = 1'b0;
    end else begin
      if (weight_biu2arb_req && weight_biu2arb_rdy && first_grant < 0) first_grant = cyc;
      if (weight_biu2arb_req && weight_biu2arb_vld && weight_biu2arb_rdy) begin
        addr_q.push_back(weight_biu2arb_addr);
        if (first_acc < 0) first_acc = cyc;
        d = cyc + int'($urandom_range(dmax, dmin));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        pend_addr.push_back(weight_biu2arb_addr);
        pend_due.push_back(d);
      end
      if (arb2weight_biu_vld && arb2weight_biu_rdy) begin
        push_cnt++;
        if (first_push < 0) first_push = cyc;
      end
      if (wbuf_vld && first_wv < 0) first_wv = cyc;
      if (wbuf_vld && wbuf_rdy) data_q.push_back(wbuf_data);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (start) start_cyc = cyc;
      if (weight_biu2arb_req) req_cycles++;
      if (weight_biu2arb_vld) vld_cycles++;
      if (wbuf_vld) wv_cycles++;
      if (prev_req && !weight_biu2arb_req) rsp_at_fall = push_cnt;
      prev_req = weight_biu2arb_req;
      req_run = weight_biu2arb_req ? req_run + 1 : 0;
    end
  end

  // Arbiter model: grant after arb_lag cycles of req, in-order responses when due.
  always @(posedge clk) begin
    #1;
    weight_biu2arb_rdy = (req_run >= arb_lag) && (req_run > 0) && (!arb_toggle || tog);
    tog = ~tog;
    if (rst_n && pend_due.size() > 0 && pend_due[0] <= cyc + 1) begin
      arb2weight_biu_vld  = 1'b1;
      arb2weight_biu_data = pend_addr[0] ^ KEY;
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      arb2weight_biu_vld  = 1'b0;
      arb2weight_biu_data = '0;
    end
  end

  task automatic start_xfer(input logic [31:0] b, input logic [15:0] n);
    @(posedge clk); #2;
    base_addr = b;
    word_num  = n;
    start     = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    repeat (3) @(posedge clk);
    #2;
    chk({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    chk({tag, " busy after done"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic check_xfer(input string tag, input logic [31:0] b, input int n);
    logic [31:0] a0;
    logic [31:0] e;
    a0 = {b[31:2], 2'b00};
    chk({tag, " commands"}, 32'(addr_q.size()), 32'(n));
    chk({tag, " words"}, 32'(data_q.size()), 32'(n));
    chk({tag, " rsp at req fall"}, 32'(rsp_at_fall), 32'(n));
    for (int i = 0; i < n; i++) begin
      e = a0 + 32'(4 * i);
      chk({tag, " addr"}, (i < addr_q.size()) ? addr_q[i] : 32'hDEAD_BEEF, e);
      chk({tag, " data"}, (i < data_q.size()) ? data_q[i] : 32'hDEAD_BEEF, e ^ KEY);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " busy"}, {31'b0, busy}, 32'd0);
    chk({tag, " done"}, {31'b0, done}, 32'd0);
    chk({tag, " req"}, {31'b0, weight_biu2arb_req}, 32'd0);
    chk({tag, " vld"}, {31'b0, weight_biu2arb_vld}, 32'd0);
    chk({tag, " addr"}, weight_biu2arb_addr, 32'd0);
    chk({tag, " rsp rdy"}, {31'b0, arb2weight_biu_rdy}, 32'd0);
    chk({tag, " wbuf_vld"}, {31'b0, wbuf_vld}, 32'd0);
    chk({tag, " wbuf_data"}, wbuf_data, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    clear_logs();
    // Reset state.
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // 4 words, grant 2 cycles after req, fixed response delay.
    clear_logs();
    arb_lag = 2; dmin = 2; dmax = 2; wbuf_rdy = 1'b1;
    start_xfer(32'h2000_0000, 16'd4);
    wait_done("t1", 200);
    check_xfer("t1", 32'h2000_0000, 4);
    chk("t1 grant->cmd latency", 32'(first_acc - first_grant), 32'd1);
    chk("t1 push->wbuf_vld latency", 32'(first_wv - first_push), 32'd1);

    // Zero-length transfer.
    clear_logs();
    start_xfer(32'h0000_1234, 16'd0);
    wait_done("t2", 50);
    chk("t2 done delay", 32'(done_cyc - start_cyc), 32'd2);
    chk("t2 req cycles", 32'(req_cycles), 32'd0);
    chk("t2 vld cycles", 32'(vld_cycles), 32'd0);
    chk("t2 wbuf_vld cycles", 32'(wv_cycles), 32'd0);

    // Credit limit: weight buffer stalled for 50 cycles; a start while busy is ignored.
    clear_logs();
    arb_lag = 1; dmin = 1; dmax = 3; wbuf_rdy = 1'b0;
    start_xfer(32'h0000_1000, 16'd20);
    repeat (20) @(posedge clk);
    start_xfer(32'h8000_0000, 16'd1);
    repeat (26) @(posedge clk);
    @(negedge clk);
    chk("t3 vld held low", {31'b0, weight_biu2arb_vld}, 32'd0);
    chk("t3 issued at credit limit", 32'(addr_q.size()), 32'd8);
    chk("t3 responses pushed", 32'(push_cnt), 32'd8);
    chk("t3 fifo full, wbuf_vld", {31'b0, wbuf_vld}, 32'd1);
    wbuf_rdy = 1'b1;
    wait_done("t3", 1000);
    check_xfer("t3", 32'h0000_1000, 20);

    // Toggling rdy, random delay, address wrap past 2^32, low bits ignored.
    clear_logs();
    arb_toggle = 1'b1; arb_lag = 1; dmin = 1; dmax = 5;
    start_xfer(32'hFFFF_FFF3, 16'd16);
    wait_done("t4", 1000);
    check_xfer("t4", 32'hFFFF_FFF3, 16);
    arb_toggle = 1'b0;

    // Reset mid-transfer after 3 of 10 commands, then a fresh transfer.
    clear_logs();
    arb_lag = 1; dmin = 3; dmax = 5;
    start_xfer(32'h0000_4000, 16'd10);
    k = 0;
    while (addr_q.size() < 3 && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    chk("t5 three issued before reset", 32'(addr_q.size()), 32'd3);
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("t5 after reset");
    clear_logs();
    start_xfer(32'h0000_0100, 16'd2);
    wait_done("t5", 200);
    check_xfer("t5", 32'h0000_0100, 2);

`ifdef WEIGHT_BIU_PERF_EN
    // rdy held low for the first 5 cycles of req.
    clear_logs();
    arb_lag = 5; dmin = 2; dmax = 2;
    start_xfer(32'h0000_0300, 16'd2);
    wait_done("t6", 200);
    chk("t6 perf_stall_cnt", perf_stall_cnt, 32'd5);
    check_xfer("t6", 32'h0000_0300, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/weight_biu.md
Name: weight_biu

Overview:
- Read-side bus interface unit for convolution weights; sits directly upstream of the ICB arbiter on its weight channel.
- Given a base address and word count, it requests the arbiter, issues sequential 32-bit read commands and collects the read responses.
- Responses are buffered in a local FIFO and streamed to the weight buffer.
- The arbiter's response path has no back-pressure, so the block reserves FIFO space before issuing each command (credit scheme).

Parameters:
- FIFO_DEPTH, 8, response FIFO entries (power of 2, >=2); also the credit limit.
- CNT_W, 16, width of the word counters and of word_num.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; launches a transfer when idle
- base_addr  in  32  byte address of the first weight word; bits[1:0] ignored
- word_num  in  CNT_W  number of 32-bit words to fetch
- busy  out  1  high from the start acceptance until the done pulse
- done  out  1  one-cycle pulse after the last word is popped to the weight buffer
- weight_biu2arb_req  out  1  arbitration request
- weight_biu2arb_addr  out  32  read command address
- weight_biu2arb_vld  out  1  read command valid
- weight_biu2arb_rdy  in  1  arbiter grant/ready
- arb2weight_biu_data  in  32  read response data
- arb2weight_biu_vld  in  1  read response valid
- arb2weight_biu_rdy  out  1  response ready
- wbuf_data  out  32  weight word to the weight buffer
- wbuf_vld  out  1  wbuf_data valid
- wbuf_rdy  in  1  weight buffer ready

Behaviour:
- Reset (synchronous, active-low): all outputs 0, state IDLE, counters and FIFO cleared.
- Reset mid-transfer aborts immediately: req drops and FIFO contents are discarded.
- FSM states: IDLE, REQ, WAIT_RSP, FLUSH, DONE.
- IDLE:
  - start with word_num != 0: latch base_addr and word_num, clear issue_cnt, rsp_cnt and pop_cnt, go to REQ, busy=1.
  - start with word_num == 0: go to DONE directly; req is never raised.
- REQ:
  - weight_biu2arb_req=1.
  - vld = rdy_held_req & (issue_cnt < word_num) & (outstanding + fifo_cnt < FIFO_DEPTH).
  - outstanding = issue_cnt - rsp_cnt.
  - A command is accepted on a cycle with vld & rdy. On acceptance: issue_cnt++, addr = {base_addr[31:2],2'b00} + 4*issue_cnt.
  - addr is combinational from issue_cnt and wraps modulo 2^32.
  - When issue_cnt reaches word_num on acceptance, go to WAIT_RSP; vld is 0 from the next cycle.
- WAIT_RSP:
  - req stays 1 until rsp_cnt == word_num, so the arbiter keeps routing responses here.
  - Then req drops and the FSM goes to FLUSH.
- The req and vld fields are never high in IDLE, FLUSH or DONE.
- A rdy seen while req is low (arbiter grant lag of up to 2 cycles) is ignored.
- arb2weight_biu_rdy = 1 in REQ and WAIT_RSP, else 0.
  - Each arb2weight_biu_vld pushes data into the FIFO and increments rsp_cnt.
  - The credit rule guarantees the FIFO is never full on a push. A push while full is a design error; assert it in simulation.
- FIFO:
  - Show-ahead: wbuf_vld = !empty, wbuf_data = head entry; pop on wbuf_vld & wbuf_rdy; pop_cnt++.
  - Simultaneous push and pop on the same cycle keeps fifo_cnt unchanged; this is legal also when the FIFO holds exactly one entry or is full.
  - Words are delivered in address order.
- FLUSH: wait until pop_cnt == word_num, then go to DONE.
- DONE: done=1 for one cycle, busy=0 on the following cycle, back to IDLE.
- start is ignored while busy.
- Latency: the first command issues 1 cycle after rdy is seen with req high; the first wbuf_vld comes 1 cycle after the first response push.

Optional Feature:
- Macro WEIGHT_BIU_PERF_EN.
- Defined: adds output port perf_stall_cnt[31:0], cleared on start acceptance. It increments each cycle in REQ/WAIT_RSP where (req & !rdy), or where the credit limit blocks vld while issue_cnt < word_num. It holds its value after done.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- base_addr=0x2000_0000, word_num=4, rdy granted 2 cycles after req, wbuf_rdy=1 -> addrs 0x20000000/04/08/0C; wbuf_data in the same order; req drops after the 4th response; one done pulse.
- word_num=0 start -> done pulse exactly 2 cycles after start; req, vld and wbuf_vld never assert.
- word_num=20, wbuf_rdy=0 for the first 50 cycles -> exactly FIFO_DEPTH=8 commands issued, then vld held 0; no response lost; all 20 words delivered in order once wbuf_rdy=1.
- rdy toggled 1/0 every cycle, random 1-5 cycle response delay, word_num=16 -> the 16 addresses are unique, sequential and 4 apart; rsp_cnt reaches 16 before req drops.
- rst_n low for 1 cycle after 3 of 10 words issued -> next cycle all outputs 0 and FIFO empty; a new start with word_num=2 completes normally.
- WEIGHT_BIU_PERF_EN defined, rdy held low 5 cycles after req, word_num=2 -> perf_stall_cnt=5 at done.
